// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, nextState;

    logic [CW-1:0]      iterCnt;
    logic               opDiv, negRes, negRem, divZero;
    logic [2*WIDTH-1:0] prodAcc, mcandSh;
    logic [WIDTH-1:0]   bReg, quo, rem, hiReg, loReg;

    logic               signedOp, aNeg, bNeg, bIsZero, calcLast, trialFits;
    logic [WIDTH-1:0]   aMag, bMag, quoFix, remFix;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH:0]     trial, trialDiff;

    assign signedOp = ~op[0];
    assign aNeg     = signedOp & a[WIDTH-1];
    assign bNeg     = signedOp & b[WIDTH-1];
    assign aMag     = aNeg ? -a : a;
    assign bMag     = bNeg ? -b : b;
    assign bIsZero  = (b == '0);

    // Restoring division step: quo shifts its dividend bits into rem, quotient bits in at the LSB.
    assign trial     = {rem, quo[WIDTH-1]};
    assign trialDiff = trial - {1'b0, bReg};
    assign trialFits = ~trialDiff[WIDTH];

    assign prodFix = negRes ? -prodAcc : prodAcc;
    assign quoFix  = negRes ? -quo : quo;
    assign remFix  = negRem ? -rem : rem;

    always_comb begin
        calcLast = (iterCnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!opDiv && (bReg[WIDTH-1:1] == '0)) calcLast = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = (op[1] && bIsZero) ? DONE : CALC;
            CALC: if (calcLast) nextState = FIX;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iterCnt <= '0;
            opDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            prodAcc <= '0;
            mcandSh <= '0;
            bReg    <= '0;
            quo     <= '0;
            rem     <= '0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        divZero <= op[1] & bIsZero;
                        opDiv   <= op[1];
                        negRes  <= aNeg ^ bNeg;
                        negRem  <= aNeg;
                        iterCnt <= '0;
                        prodAcc <= '0;
                        mcandSh <= {{WIDTH{1'b0}}, aMag};
                        bReg    <= bMag;
                        quo     <= aMag;
                        rem     <= '0;
                    end
                end
                CALC: begin
                    iterCnt <= iterCnt + CW'(1);
                    if (opDiv) begin
                        rem <= trialFits ? trialDiff[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], trialFits};
                    end else begin
                        // Multiplicand shifts left instead of the accumulator shifting right,
                        // so the product is already aligned whenever CALC ends.
                        if (bReg[0]) prodAcc <= prodAcc + mcandSh;
                        mcandSh <= mcandSh << 1;
                        bReg    <= bReg >> 1;
                    end
                end
                default: ;
            endcase

            if (state == FIX) begin
                if (opDiv) begin
                    hiReg <= remFix;
                    loReg <= quoFix;
                end else begin
                    hiReg <= prodFix[2*WIDTH-1:WIDTH];
                    loReg <= prodFix[WIDTH-1:0];
                end
            end else if (state == IDLE || state == DONE) begin
                if (hi_we) hiReg <= wdata;
                if (lo_we) loReg <= wdata;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign div_zero = divZero;
    assign hi       = hiReg;
    assign lo       = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        hi_we, lo_we;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int tests  = 0;
    int failed = 0;
    logic [31:0] mHi = '0, mLo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, latency counted in negedges after the accept edge.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eHi, output logic [31:0] eLo,
                         output logic eDz, output int eLat);
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0] up;
        logic [31:0] bm;
        int p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        eHi = mHi; eLo = mLo; eDz = 1'b0; eLat = 34;
        case (o)
            2'd0: begin sp = sx * sy; up = sp; eHi = up[63:32]; eLo = up[31:0]; end
            2'd1: begin up = {32'b0, x} * {32'b0, y}; eHi = up[63:32]; eLo = up[31:0]; end
            2'd2: if (y == 0) begin eDz = 1'b1; eLat = 1; end
                  else begin
                      sq = sx / sy; sr = sx % sy;
                      up = sq; eLo = up[31:0];
                      up = sr; eHi = up[31:0];
                  end
            default: if (y == 0) begin eDz = 1'b1; eLat = 1; end
                     else begin eLo = x / y; eHi = x % y; end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            bm = (o == 2'd0 && y[31]) ? -y : y;
            p = 0;
            for (int i = 0; i < 32; i++) if (bm[i]) p = i;
            eLat = p + 3;
        end
`endif
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit disturb);
        logic [31:0] eHi, eLo;
        logic eDz;
        int eLat, n;
        bit busyOk;
        model(o, x, y, eHi, eLo, eDz, eLat);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        n = 0; busyOk = 1'b1;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (!busy) busyOk = 1'b0;
            start = 1'b0; hi_we = 1'b0;
            if (done) break;
            if (disturb && n == 3) begin
                start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
        end
        check({tag, " latency"}, n, eLat);
        check({tag, " busy"}, busyOk, 1'b1);
        check({tag, " hi"}, hi, eHi);
        check({tag, " lo"}, lo, eLo);
        check({tag, " div_zero"}, div_zero, eDz);
        @(negedge clock);
        check({tag, " idle after"}, {busy, done}, 2'b00);
        mHi = eHi; mLo = eLo;
    endtask

    initial begin
        bit sawDone;
        logic [1:0] ro;
        logic [31:0] rx, ry;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #12;
        check("reset outputs", {hi, lo, busy, done, div_zero}, '0);
        @(negedge clock);
        reset = 1'b1;

        runOp("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("mult -3*5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        runOp("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        runOp("divu 100/7", 2'd3, 32'd100, 32'd7, 1'b0);

        @(negedge clock); hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clock); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clock); lo_we = 1'b0;
        check("preload", {hi, lo}, {32'h1234, 32'h5678});
        mHi = 32'h1234; mLo = 32'h5678;
        runOp("div by zero", 2'd2, 32'd55, 32'd0, 1'b0);

        runOp("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runOp("multu 7*2", 2'd1, 32'd7, 32'd2, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            runOp("random", ro, rx, ry, i[0]);
        end

        @(negedge clock); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clock); hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'd1; a = 32'h0001_0003; b = 32'h8000_0001;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1 check("async reset", {hi, lo, busy, done}, '0);
        sawDone = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done) sawDone = 1'b1;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) sawDone = 1'b1;
        end
        check("no done after reset", sawDone, 1'b0);
        mHi = '0; mLo = '0;
        runOp("after reset", 2'd3, 32'd1000, 32'd33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS datapath.
- Replaces separate fixed 32-bit mult/div blocks and their HI/LO select muxes with one WIDTH-generic unit.
- Supports signed and unsigned MULT and DIV, MTHI/MTLO writes, divide-by-zero flagging and a busy/done handshake toward the control unit.

Parameters:
- WIDTH, 32, operand, HI and LO width in bits (must be >= 4).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- hi_we  in  1  write wdata to HI (MTHI).
- lo_we  in  1  write wdata to LO (MTLO).
- wdata  in  WIDTH  HI/LO write data.
- busy  out  1  high while an operation is in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  valid with done: last DIV/DIVU had divisor 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Any in-flight operation is discarded.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - start=1 at edge k accepts the operation: a, b and op are latched.
  - For signed ops, magnitudes are latched, plus result-sign flags.
  - Normal transition is to CALC with iteration counter = 0.
- **CALC:** one radix-2 iteration per cycle; exactly WIDTH cycles, then FIX.
  - Multiply: shift-add of |a| by the bits of |b|, LSB first, into a 2*WIDTH accumulator.
  - Divide: restoring division of |a| by |b|, MSB first; yields quotient Q and remainder R.
- **FIX:** one cycle of sign correction.
  - MULT: 2*WIDTH product is negated if sign(a) != sign(b).
  - DIV: Q is negated if sign(a) != sign(b); R takes the sign of a.
  - Unsigned ops pass through unchanged.
- **DONE:** one cycle, then IDLE.
  - On the FIX->DONE edge: MULT/MULTU write {hi,lo} = product; DIV/DIVU write lo = Q, hi = R.
  - done=1 for this cycle.
- **Latency:** start accepted at edge k gives done=1 in the cycle after edge k+WIDTH+2 (k+34 for WIDTH=32). busy=1 from edge k through the DONE cycle.
- **Divide by zero:** DIV/DIVU with b=0 at accept.
  - Transition is IDLE->DONE directly; done is high after edge k+1.
  - div_zero=1; hi and lo are unchanged.
  - div_zero is cleared at the next accepted start.
- **Signed overflow:** DIV of MIN by -1 gives lo=MIN, hi=0 (natural result of the magnitude algorithm; no flag).
- **Start while busy:** ignored, not queued.
- **HI/LO writes:**
  - hi_we/lo_we take effect at the clock edge only when busy=0, including the DONE-exit edge back to IDLE.
  - Writes while busy=1 are dropped.
  - start and hi_we/lo_we in the same IDLE cycle: the write happens now; the operation result later overwrites it.
- **Operand stability:** a, b and op may change after the accept edge without effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- **Defined:** MULT/MULTU leave CALC as soon as the remaining unprocessed bits of |b| are all zero.
  - CALC lasts p+1 cycles, where p is the index of the highest set bit of |b|; 1 cycle if b=0.
  - done comes at edge k+p+3.
  - Division timing is unchanged.
- **Undefined:** fixed WIDTH CALC cycles for all ops; no early-out logic is present.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after accept, busy high throughout.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
- Preload via hi_we/lo_we hi=0x1234, lo=0x5678; then DIV b=0 -> done 1 cycle after accept, div_zero=1, hi=0x1234, lo=0x5678.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; a second start and an hi_we pulse during busy are both ignored.
- Drive reset low mid-CALC -> hi=lo=0, busy=0 immediately, no done pulse; with MULDIV_EARLY_OUT_EN, MULTU 7*2 -> lo=14, done at k+4.
